mem_bus_if: RTL and testbench

Memory access adapter between the multicycle RISC-V datapath and a word-wide request/acknowledge memory bus. It accepts one load or store per `start` pulse, with a byte address, store data and a `mem_dt_e` data type. It drives an aligned bus transaction with byte-lane enables, then returns the lane-extracted, sign- or zero-extended load result. It raises `busy` so the controller's MEM_READ / MEM_WRITE states can stall on slow memory, and it flags misaligned or invalid accesses.

---
 rtl/mem_bus_if.sv | 190 +++++++++++++++++++
 tb/tb_mem_bus_if.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_if.sv
// Load/store adapter from the multicycle datapath to a word-wide req/ack memory bus.
// Optional REQ-phase timeout is compiled in with `define MEM_BUS_IF_TIMEOUT_EN.
package mem_bus_if_pkg;
    typedef enum logic [2:0] {
        BYTE  = 3'd0,
        HALF  = 3'd1,
        WORD  = 3'd2,
        UBYTE = 3'd3,
        UHALF = 3'd4,
        NONE  = 3'd5
    } mem_dt_e;
endpackage

module mem_bus_if
    import mem_bus_if_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  mem_dt_e     dt,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rd,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    state_e      state_reg, state_next;
    mem_dt_e     dt_reg;
    logic [1:0]  off_reg;
    logic        bus_we_reg;
    logic [31:0] bus_addr_reg;
    logic [3:0]  bus_be_reg;
    logic [31:0] bus_wdata_reg;
    logic [31:0] rd_reg;

    logic        req_bad;
    logic [3:0]  be_dec;
    logic [31:0] wdata_dec;
    logic        tmo_hit;

    // Request decode: alignment check, lane enables and lane-replicated store data.
    always_comb begin
        req_bad   = 1'b0;
        be_dec    = 4'b0000;
        wdata_dec = wd;
        case (dt)
            BYTE, UBYTE: begin
                be_dec    = 4'b0001 << addr[1:0];
                wdata_dec = {4{wd[7:0]}};
            end
            HALF, UHALF: begin
                req_bad   = addr[0];
                be_dec    = 4'b0011 << addr[1:0];
                wdata_dec = {2{wd[15:0]}};
            end
            WORD: begin
                req_bad = |addr[1:0];
                be_dec  = 4'b1111;
            end
            default: req_bad = 1'b1;
        endcase
    end

    logic [7:0]  rbyte [4];
    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    logic [31:0] rd_ext;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign rbyte[gi] = bus_rdata[8*gi +: 8];
    end

    assign sel_b = rbyte[off_reg];
    assign sel_h = off_reg[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    always_comb begin
        rd_ext = bus_rdata;
        case (dt_reg)
            BYTE:    rd_ext = {{24{sel_b[7]}}, sel_b};
            UBYTE:   rd_ext = {24'd0, sel_b};
            HALF:    rd_ext = {{16{sel_h[15]}}, sel_h};
            UHALF:   rd_ext = {16'd0, sel_h};
            default: rd_ext = bus_rdata;
        endcase
    end

`ifdef MEM_BUS_IF_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt_reg;

    // Counter sits at zero outside REQ, so it is already cleared on REQ entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg != S_REQ) begin
            tmo_cnt_reg <= '0;
        end else if (!bus_ack) begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end
    end

    assign tmo_hit = (tmo_cnt_reg == CW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // An ack on the final allowed REQ cycle takes priority over the timeout.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = req_bad ? S_ERR : S_REQ;
                end
            end
            S_REQ: begin
                if (bus_ack) begin
                    state_next = S_RESP;
                end else if (tmo_hit) begin
                    state_next = S_ERR;
                end
            end
            S_RESP:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dt_reg        <= BYTE;
            off_reg       <= 2'd0;
            bus_we_reg    <= 1'b0;
            bus_addr_reg  <= 32'd0;
            bus_be_reg    <= 4'd0;
            bus_wdata_reg <= 32'd0;
            rd_reg        <= 32'd0;
        end else begin
            if (state_reg == S_IDLE && start && !req_bad) begin
                dt_reg        <= dt;
                off_reg       <= addr[1:0];
                bus_we_reg    <= we;
                bus_addr_reg  <= {addr[31:2], 2'b00};
                bus_be_reg    <= be_dec;
                bus_wdata_reg <= wdata_dec;
            end
            if (state_reg == S_REQ && bus_ack && !bus_we_reg) begin
                rd_reg <= rd_ext;
            end
        end
    end

    assign busy      = (state_reg != S_IDLE);
    assign done      = (state_reg == S_RESP) || (state_reg == S_ERR);
    assign err       = (state_reg == S_ERR);
    assign bus_req   = (state_reg == S_REQ);
    assign bus_we    = bus_we_reg;
    assign bus_addr  = bus_addr_reg;
    assign bus_be    = bus_be_reg;
    assign bus_wdata = bus_wdata_reg;
    assign rd        = rd_reg;

endmodule

// File: tb/tb_mem_bus_if.sv
// Self-checking bench for mem_bus_if: directed cases plus randomized accesses
// checked against an arithmetic model of the load/store rules.
module tb_mem_bus_if;
    import mem_bus_if_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    mem_dt_e     dt;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rd;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int          checks = 0;
    int          passes = 0;
    logic [31:0] rd_model = 32'd0;

    always #5 clk = ~clk;

    mem_bus_if #(.TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .we        (we),
        .addr      (addr),
        .wd        (wd),
        .dt        (dt),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rd        (rd),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int size_of(mem_dt_e d);
        case (d)
            BYTE, UBYTE: return 1;
            HALF, UHALF: return 2;
            WORD:        return 4;
            default:     return 0;
        endcase
    endfunction

    function automatic bit is_bad(mem_dt_e d, logic [31:0] a);
        int sz = size_of(d);
        if (sz == 0) return 1'b1;
        return (a % sz) != 0;
    endfunction

    function automatic logic [31:0] exp_be(mem_dt_e d, logic [31:0] a);
        int sz = size_of(d);
        int v = ((1 << sz) - 1) << (a % 4);
        return v & 32'hF;
    endfunction

    function automatic logic [31:0] exp_wdata(mem_dt_e d, logic [31:0] v);
        int sz = size_of(d);
        if (sz == 1) return (v & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (v & 32'hFFFF) * 32'h0001_0001;
        return v;
    endfunction

    function automatic logic [31:0] exp_load(mem_dt_e d, logic [31:0] a, logic [31:0] r);
        int unsigned o = a % 4;
        logic [31:0] v;
        if (size_of(d) == 1) begin
            v = (r >> (8 * o)) & 32'hFF;
            if (d == BYTE && v >= 128) v = v - 32'd256;
            return v;
        end
        if (size_of(d) == 2) begin
            v = (r >> (8 * (o - o % 2))) & 32'hFFFF;
            if (d == HALF && v >= 32768) v = v - 32'd65536;
            return v;
        end
        return r;
    endfunction

    // One full access starting from IDLE; k = REQ cycles without ack before the ack cycle.
    task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d,
                          input mem_dt_e t, input int k, input logic [31:0] rdata,
                          input bit spurious);
        bit bad = is_bad(t, a);
        int cyc = 1;
        we = w; addr = a; wd = d; dt = t; start = 1'b1;
        tick();
        start = 1'b0; addr = $urandom; wd = $urandom; we = ~w;
        if (bad) begin
            chk("err_done", done, 1);
            chk("err_flag", err, 1);
            chk("err_busreq", bus_req, 0);
            chk("err_busy", busy, 1);
            chk("err_rd", rd, rd_model);
            tick();
            chk("err_idle_busy", busy, 0);
            chk("err_idle_done", done, 0);
            $display("access we=%0d addr=%08h dt=%0d -> err cycle 1", w, a, t);
            return;
        end
        for (int i = 0; i <= k; i++) begin
            chk("req", bus_req, 1);
            chk("req_busy", busy, 1);
            chk("req_done", done, 0);
            chk("req_addr", bus_addr, a & 32'hFFFF_FFFC);
            chk("req_be", bus_be, exp_be(t, a));
            chk("req_we", bus_we, w);
            if (w) chk("req_wdata", bus_wdata, exp_wdata(t, d));
            if (spurious && i == 0) begin
                start = 1'b1;
                dt = WORD;
                addr = $urandom & 32'hFFFF_FFFC;
            end
            if (i == k) begin
                bus_ack = 1'b1;
                bus_rdata = rdata;
            end else begin
                bus_ack = 1'b0;
                bus_rdata = $urandom;
            end
            tick();
            cyc++;
            start = 1'b0;
        end
        bus_ack = 1'b0;
        bus_rdata = $urandom;
        if (!w) rd_model = exp_load(t, a, rdata);
        chk("resp_done", done, 1);
        chk("resp_err", err, 0);
        chk("resp_busreq", bus_req, 0);
        chk("resp_busy", busy, 1);
        chk("resp_rd", rd, rd_model);
        tick();
        chk("after_busy", busy, 0);
        chk("after_done", done, 0);
        chk("after_rd", rd, rd_model);
        $display("access we=%0d addr=%08h dt=%0d k=%0d -> done cycle %0d rd=%08h",
                 w, a, t, k, cyc, rd);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; we = 1'b0; addr = 32'd0; wd = 32'd0; dt = BYTE;
        bus_rdata = 32'd0; bus_ack = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_busreq", bus_req, 0);
        chk("rst_rd", rd, 0);
        chk("rst_be", bus_be, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        access(1'b0, 32'h0000_1003, 32'd0, BYTE, 0, 32'h80FF_FFFF, 1'b0);
        chk("tp_load_byte", rd, 32'hFFFF_FF80);
        access(1'b1, 32'h0000_2002, 32'h1234_ABCD, HALF, 3, 32'd0, 1'b0);
        access(1'b0, 32'h0000_0001, 32'd0, UBYTE, 0, 32'h0000_F000, 1'b0);
        chk("tp_ubyte", rd, 32'h0000_00F0);
        access(1'b0, 32'h0000_0002, 32'd0, UHALF, 1, 32'h8001_0000, 1'b1);
        chk("tp_uhalf", rd, 32'h0000_8001);
        access(1'b0, 32'h0000_0006, 32'd0, WORD, 0, 32'd0, 1'b0);
        chk("tp_misaligned_rd", rd, 32'h0000_8001);

        // Ack while idle must be ignored.
        bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        tick();
        tick();
        chk("idle_ack_busy", busy, 0);
        chk("idle_ack_rd", rd, rd_model);
        bus_ack = 1'b0;
        $display("idle ack ignored rd=%08h", rd);

`ifdef MEM_BUS_IF_TIMEOUT_EN
        we = 1'b0; addr = 32'h0000_0100; dt = WORD; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("tmo_req", bus_req, 1);
            chk("tmo_done", done, 0);
            start = (i == 1);
            tick();
        end
        start = 1'b0;
        chk("tmo_done_end", done, 1);
        chk("tmo_err", err, 1);
        chk("tmo_busreq", bus_req, 0);
        chk("tmo_rd", rd, rd_model);
        tick();
        chk("tmo_idle", busy, 0);
        $display("timeout access -> err after 4 REQ cycles");
`endif

        // Asynchronous reset in the middle of REQ.
        we = 1'b0; addr = 32'h0000_0040; dt = WORD; start = 1'b1;
        tick();
        start = 1'b0;
        chk("mid_req", bus_req, 1);
        #2 rst = 1'b1;
        #1;
        rd_model = 32'd0;
        chk("arst_busreq", bus_req, 0);
        chk("arst_busy", busy, 0);
        chk("arst_rd", rd, 0);
        chk("arst_addr", bus_addr, 0);
        chk("arst_wdata", bus_wdata, 0);
        chk("arst_we", bus_we, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        $display("async reset mid-REQ -> idle");
        access(1'b0, 32'h0000_0044, 32'd0, WORD, 2, 32'hCAFE_F00D, 1'b0);

        for (int n = 0; n < 60; n++) begin
            logic [31:0] ra;
            mem_dt_e     rt;
            ra = $urandom;
            if ($urandom_range(0, 1) == 1) ra = ra & 32'hFFFF_FFFE;
            rt = mem_dt_e'($urandom_range(0, 7));
            access(1'($urandom_range(0, 1)), ra, $urandom, rt,
                   int'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
